wb_commit: RTL and testbench
============================

Name: wb_commit

Overview:
- Writeback/commit end of the dual-issue path: the counterpart to the launch stage that dispatches two decoded instructions to the execution units.
- Launch allocates program-ordered tags here, up to two per cycle.
- The two execution units return results tagged out of order.
- This block retires up to two results per cycle, strictly in program order, onto the two register-file write ports.

Parameters:
DEPTH, 8, number of in-flight entries (power of 2, >=4)
TAG_W, 3, log2(DEPTH)
DATA_W, 32, result data width
REG_W, 5, register address width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
stop  in  1  pipeline hold: no alloc, no commit; result capture continues
alloc_num  in  2  instructions launch wants to allocate this cycle (0,1,2; 3 illegal)
alloc_ok  out  1  allocation granted this cycle (combinational)
alloc_tag0  out  TAG_W  tag for older launched instruction
alloc_tag1  out  TAG_W  tag for younger launched instruction
res1_valid  in  1  execution unit 1 result valid
res1_tag  in  TAG_W  tag of result 1
res1_we  in  1  result 1 writes a register
res1_rd  in  REG_W  destination register of result 1
res1_data  in  DATA_W  result 1 value
res2_valid, res2_tag, res2_we, res2_rd, res2_data  in  same as res1, execution unit 2
wb1_we  out  1  register-file write port 1 enable (older commit)
wb1_addr  out  REG_W  port 1 address
wb1_data  out  DATA_W  port 1 data
wb2_we  out  1  port 2 enable (younger commit)
wb2_addr  out  REG_W  port 2 address
wb2_data  out  DATA_W  port 2 data
count  out  TAG_W+1  occupied entries
full  out  1  count==DEPTH
empty  out  1  count==0

Behaviour:
- Storage: DEPTH entries, each holding state FREE/BUSY/DONE plus we, rd and data. Circular head (oldest) and tail pointers, TAG_W bits, wrap modulo DEPTH.
- Reset: all entries FREE; head=tail=0; count=0; all wb* outputs 0. Reset overrides every other input in the same cycle.
- Allocation:
  - alloc_ok = !stop && (DEPTH-count) >= alloc_num, using the registered count only; no bypass of same-cycle commits.
  - alloc_tag0=tail, alloc_tag1=tail+1 (mod DEPTH), always driven.
  - On alloc_ok with alloc_num=n, entries tail..tail+n-1 become BUSY and tail advances by n at the clock edge.
  - alloc_num=0 gives alloc_ok=1 with no state change.
- Result capture, every cycle regardless of stop:
  - resX_valid on a BUSY entry stores we/rd/data and sets the entry DONE.
  - Valid on a FREE or DONE entry is ignored.
  - Both results carrying the same tag is illegal; res1 wins.
  - Data captured at edge N is committable at edge N+1 at the earliest; no same-cycle result-to-commit bypass.
- Commit, only when !stop:
  - c0 = head entry is DONE.
  - c1 = c0 && entry head+1 is DONE && count>=2.
  - Committed entries become FREE and head advances by c0+c1.
  - count_next = count + allocated - committed.
- Writeback outputs are registered, one cycle after the commit decision:
  - wb1 carries the head entry, wb2 carries head+1.
  - wbX_we = committed && entry.we && rd!=0.
  - If both commit with equal nonzero rd and both we=1, wb1_we is forced 0 (the younger write wins).
  - If nothing commits on a port, that port's we is 0 and its addr/data hold their previous values.
- stop=1: the wb*_we registers load 0; head, tail and count are unchanged except by result capture.
- Full: alloc_num>=1 is rejected. Commits still drain the buffer, so alloc_ok can rise the next cycle.
- Wrap: pointers roll over from DEPTH-1 to 0. A two-entry alloc or commit may straddle the wrap.

Decomposition:
- Shared package `def.vh`:
  - entry state encodings FREE=2'd0, BUSY=2'd1, DONE=2'd2
  - WB_DEPTH/WB_TAG_W defines
  - existing DATA_BUS/PC_BUS widths
- One natural sub-module: wb_entry_ram, the entry array with 2 capture write ports and 2 read ports at head/head+1.
- Pointer and count logic stays in wb_commit.

Test Plan:
- Reset, then alloc_num=2 -> alloc_ok=1, tags 0 and 1. Return result tag1 (rd=5, data=0x11) before tag0 (rd=6, data=0x22) -> nothing commits until tag0 is DONE. Then one cycle later wb1={we1,6,0x22} and wb2={we1,5,0x11} together; count 2->0.
- Allocate 8 singles with no results -> full=1. alloc_num=1 -> alloc_ok=0. Return tag0 -> commit next cycle, and alloc_ok=1 in the cycle after count drops to 7.
- Both entries commit with rd=3 (data 0xA older, 0xB younger) -> wb1_we=0, wb2_we=1, wb2_data=0xB. A result with rd=0 gives we=0 on its port.
- Hold stop=1 for 3 cycles while results arrive -> wb*_we=0 and count unchanged. Drop stop -> commits drain two per cycle in order.
- Cycle the pointers across the wrap (head=7, alloc 2 gives tags 7 and 0) -> in-order commit across 7->0. Assert rst mid-stream -> all outputs 0 and count=0 the next cycle; a result for a stale tag is ignored.

Source files
------------

// File: rtl/wb_commit_pkg.sv
// Shared definitions for the writeback/commit slice: entry states and default sizes.
package wb_commit_pkg;
  typedef enum logic [1:0] {
    ST_FREE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } entry_st_e;

  localparam int WB_DEPTH = 8;
  localparam int WB_TAG_W = 3;
  localparam int DATA_BUS = 32;
  localparam int PC_BUS   = 32;
endpackage

// File: rtl/wb_entry_ram.sv
// In-flight entry array: per-entry state plus captured result, two capture
// write ports and two read ports for the head pair.
module wb_entry_ram
  import wb_commit_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int TAG_W  = 3,
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DEPTH-1:0]  alloc_mask,
  input  logic [DEPTH-1:0]  free_mask,
  input  logic              res1_valid,
  input  logic [TAG_W-1:0]  res1_tag,
  input  logic              res1_we,
  input  logic [REG_W-1:0]  res1_rd,
  input  logic [DATA_W-1:0] res1_data,
  input  logic              res2_valid,
  input  logic [TAG_W-1:0]  res2_tag,
  input  logic              res2_we,
  input  logic [REG_W-1:0]  res2_rd,
  input  logic [DATA_W-1:0] res2_data,
  input  logic [TAG_W-1:0]  rd0_tag,
  input  logic [TAG_W-1:0]  rd1_tag,
  output entry_st_e         rd0_st,
  output entry_st_e         rd1_st,
  output logic              rd0_we,
  output logic              rd1_we,
  output logic [REG_W-1:0]  rd0_rd,
  output logic [REG_W-1:0]  rd1_rd,
  output logic [DATA_W-1:0] rd0_data,
  output logic [DATA_W-1:0] rd1_data
);
  entry_st_e         st     [DEPTH];
  logic              we_q   [DEPTH];
  logic [REG_W-1:0]  rd_q   [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DEPTH-1:0]  hit1, hit2;

  // Only BUSY entries accept a result; res1 shadows res2 on a shared tag.
  always_comb begin
    hit1 = '0;
    hit2 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      hit1[i] = res1_valid && (res1_tag == i[TAG_W-1:0]) && (st[i] == ST_BUSY);
      hit2[i] = res2_valid && (res2_tag == i[TAG_W-1:0]) && (st[i] == ST_BUSY) && !hit1[i];
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (rst)                     st[i] <= ST_FREE;
      else if (free_mask[i])       st[i] <= ST_FREE;
      else if (alloc_mask[i])      st[i] <= ST_BUSY;
      else if (hit1[i] || hit2[i]) st[i] <= ST_DONE;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (hit1[i]) begin
        we_q[i]   <= res1_we;
        rd_q[i]   <= res1_rd;
        data_q[i] <= res1_data;
      end else if (hit2[i]) begin
        we_q[i]   <= res2_we;
        rd_q[i]   <= res2_rd;
        data_q[i] <= res2_data;
      end
    end
  end

  assign rd0_st   = st[rd0_tag];
  assign rd1_st   = st[rd1_tag];
  assign rd0_we   = we_q[rd0_tag];
  assign rd1_we   = we_q[rd1_tag];
  assign rd0_rd   = rd_q[rd0_tag];
  assign rd1_rd   = rd_q[rd1_tag];
  assign rd0_data = data_q[rd0_tag];
  assign rd1_data = data_q[rd1_tag];
endmodule

// File: rtl/wb_commit.sv
// Commit end of the dual-issue path: allocates program-ordered tags, collects
// out-of-order results and retires up to two per cycle in order.
module wb_commit
  import wb_commit_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int TAG_W  = 3,
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stop,
  input  logic [1:0]        alloc_num,
  output logic              alloc_ok,
  output logic [TAG_W-1:0]  alloc_tag0,
  output logic [TAG_W-1:0]  alloc_tag1,
  input  logic              res1_valid,
  input  logic [TAG_W-1:0]  res1_tag,
  input  logic              res1_we,
  input  logic [REG_W-1:0]  res1_rd,
  input  logic [DATA_W-1:0] res1_data,
  input  logic              res2_valid,
  input  logic [TAG_W-1:0]  res2_tag,
  input  logic              res2_we,
  input  logic [REG_W-1:0]  res2_rd,
  input  logic [DATA_W-1:0] res2_data,
  output logic              wb1_we,
  output logic [REG_W-1:0]  wb1_addr,
  output logic [DATA_W-1:0] wb1_data,
  output logic              wb2_we,
  output logic [REG_W-1:0]  wb2_addr,
  output logic [DATA_W-1:0] wb2_data,
  output logic [TAG_W:0]    count,
  output logic              full,
  output logic              empty
);
  localparam logic [TAG_W:0] DEPTH_C = (TAG_W+1)'(DEPTH);

  logic [TAG_W-1:0]  head, tail, head_p1;
  logic [TAG_W:0]    free_slots;
  logic [1:0]        n_alloc, n_commit;
  logic              c0, c1;
  logic [DEPTH-1:0]  alloc_mask, free_mask;
  entry_st_e         st0, st1;
  logic              we0, we1;
  logic [REG_W-1:0]  rd0, rd1;
  logic [DATA_W-1:0] data0, data1;

  wb_entry_ram #(.DEPTH(DEPTH), .TAG_W(TAG_W), .DATA_W(DATA_W), .REG_W(REG_W)) u_ram (
    .clk(clk), .rst(rst),
    .alloc_mask(alloc_mask), .free_mask(free_mask),
    .res1_valid(res1_valid), .res1_tag(res1_tag), .res1_we(res1_we),
    .res1_rd(res1_rd), .res1_data(res1_data),
    .res2_valid(res2_valid), .res2_tag(res2_tag), .res2_we(res2_we),
    .res2_rd(res2_rd), .res2_data(res2_data),
    .rd0_tag(head), .rd1_tag(head_p1),
    .rd0_st(st0), .rd1_st(st1), .rd0_we(we0), .rd1_we(we1),
    .rd0_rd(rd0), .rd1_rd(rd1), .rd0_data(data0), .rd1_data(data1)
  );

  assign head_p1    = head + TAG_W'(1);
  assign alloc_tag0 = tail;
  assign alloc_tag1 = tail + TAG_W'(1);

  // Grant is judged on the registered count only; same-cycle commits do not help.
  assign free_slots = DEPTH_C - count;
  assign alloc_ok   = !stop && (free_slots >= (TAG_W+1)'(alloc_num));
  assign n_alloc    = alloc_ok ? alloc_num : 2'd0;

  assign c0       = !stop && (st0 == ST_DONE);
  assign c1       = c0 && (st1 == ST_DONE) && (count >= (TAG_W+1)'(2));
  assign n_commit = {1'b0, c0} + {1'b0, c1};

  assign full  = (count == DEPTH_C);
  assign empty = (count == '0);

  always_comb begin
    alloc_mask = '0;
    free_mask  = '0;
    if (n_alloc != 2'd0) alloc_mask[tail]       = 1'b1;
    if (n_alloc == 2'd2) alloc_mask[alloc_tag1] = 1'b1;
    if (c0)              free_mask[head]        = 1'b1;
    if (c1)              free_mask[head_p1]     = 1'b1;
  end

  // Commit decision -> registered writeback ports
  always_ff @(posedge clk) begin
    if (rst) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      wb1_we   <= 1'b0;
      wb1_addr <= '0;
      wb1_data <= '0;
      wb2_we   <= 1'b0;
      wb2_addr <= '0;
      wb2_data <= '0;
    end else begin
      head  <= head + TAG_W'(n_commit);
      tail  <= tail + TAG_W'(n_alloc);
      count <= count + (TAG_W+1)'(n_alloc) - (TAG_W+1)'(n_commit);
      // A same-register pair collapses onto the younger write.
      wb1_we <= c0 && we0 && (rd0 != '0) && !(c1 && we1 && (rd1 == rd0));
      wb2_we <= c1 && we1 && (rd1 != '0);
      if (c0) begin
        wb1_addr <= rd0;
        wb1_data <= data0;
      end
      if (c1) begin
        wb2_addr <= rd1;
        wb2_data <= data1;
      end
    end
  end
endmodule

// File: tb/tb_wb_commit.sv
// Bench for wb_commit: directed scenarios then random traffic, all checked
// against an in-order queue model of the reorder buffer.
module tb_wb_commit;
  localparam int DEPTH = 8, TAG_W = 3, DATA_W = 32, REG_W = 5;

  logic              clk, rst, stop;
  logic [1:0]        alloc_num;
  logic              alloc_ok;
  logic [TAG_W-1:0]  alloc_tag0, alloc_tag1;
  logic              res1_valid, res1_we, res2_valid, res2_we;
  logic [TAG_W-1:0]  res1_tag, res2_tag;
  logic [REG_W-1:0]  res1_rd, res2_rd;
  logic [DATA_W-1:0] res1_data, res2_data;
  logic              wb1_we, wb2_we;
  logic [REG_W-1:0]  wb1_addr, wb2_addr;
  logic [DATA_W-1:0] wb1_data, wb2_data;
  logic [TAG_W:0]    count;
  logic              full, empty;

  wb_commit #(.DEPTH(DEPTH), .TAG_W(TAG_W), .DATA_W(DATA_W), .REG_W(REG_W)) dut (
    .clk(clk), .rst(rst), .stop(stop), .alloc_num(alloc_num), .alloc_ok(alloc_ok),
    .alloc_tag0(alloc_tag0), .alloc_tag1(alloc_tag1),
    .res1_valid(res1_valid), .res1_tag(res1_tag), .res1_we(res1_we),
    .res1_rd(res1_rd), .res1_data(res1_data),
    .res2_valid(res2_valid), .res2_tag(res2_tag), .res2_we(res2_we),
    .res2_rd(res2_rd), .res2_data(res2_data),
    .wb1_we(wb1_we), .wb1_addr(wb1_addr), .wb1_data(wb1_data),
    .wb2_we(wb2_we), .wb2_addr(wb2_addr), .wb2_data(wb2_data),
    .count(count), .full(full), .empty(empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: program-ordered queue of outstanding instructions, oldest first.
  typedef struct {
    bit                done;
    bit                we;
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] data;
  } ent_t;

  ent_t              q[$];
  int                m_head;
  logic              e1_we, e2_we;
  logic [REG_W-1:0]  e1_addr, e2_addr;
  logic [DATA_W-1:0] e1_data, e2_data;
  int                checks, errors;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int m_tail();
    return (m_head + q.size()) % DEPTH;
  endfunction

  task automatic capture(input logic v, input logic [TAG_W-1:0] tag, input logic we,
                         input logic [REG_W-1:0] rd, input logic [DATA_W-1:0] data);
    int   idx;
    ent_t e;
    if (!v) return;
    idx = (int'(tag) - m_head + DEPTH) % DEPTH;
    if (idx < q.size() && !q[idx].done) begin
      e = q[idx];
      e.done = 1'b1;
      e.we   = we;
      e.rd   = rd;
      e.data = data;
      q[idx] = e;
    end
  endtask

  task automatic model_edge();
    bit   ok, c0, c1;
    ent_t o0, o1;
    ent_t fresh;
    if (rst) begin
      q.delete();
      m_head = 0;
      e1_we = 0; e2_we = 0; e1_addr = '0; e2_addr = '0; e1_data = '0; e2_data = '0;
      return;
    end
    ok = !stop && ((DEPTH - q.size()) >= int'(alloc_num));
    c0 = !stop && q.size() >= 1 && q[0].done;
    c1 = c0 && q.size() >= 2 && q[1].done;
    o0 = '{default: '0};
    o1 = '{default: '0};
    if (c0) o0 = q[0];
    if (c1) o1 = q[1];
    e1_we = c0 && o0.we && (o0.rd != 0) && !(c1 && o1.we && (o1.rd == o0.rd));
    e2_we = c1 && o1.we && (o1.rd != 0);
    if (c0) begin e1_addr = o0.rd; e1_data = o0.data; end
    if (c1) begin e2_addr = o1.rd; e2_data = o1.data; end
    if (c0) void'(q.pop_front());
    if (c1) void'(q.pop_front());
    m_head = (m_head + int'(c0) + int'(c1)) % DEPTH;
    capture(res1_valid, res1_tag, res1_we, res1_rd, res1_data);
    capture(res2_valid, res2_tag, res2_we, res2_rd, res2_data);
    fresh = '{default: '0};
    if (ok) for (int k = 0; k < int'(alloc_num); k++) q.push_back(fresh);
  endtask

  task automatic tick();
    #1;
    if (!rst) begin
      chk("alloc_ok", alloc_ok, (!stop && ((DEPTH - q.size()) >= int'(alloc_num))) ? 1 : 0);
      chk("alloc_tag0", alloc_tag0, m_tail());
      chk("alloc_tag1", alloc_tag1, (m_tail() + 1) % DEPTH);
    end
    @(posedge clk);
    model_edge();
    #1;
    chk("wb1_we", wb1_we, e1_we);
    chk("wb1_addr", wb1_addr, e1_addr);
    chk("wb1_data", wb1_data, e1_data);
    chk("wb2_we", wb2_we, e2_we);
    chk("wb2_addr", wb2_addr, e2_addr);
    chk("wb2_data", wb2_data, e2_data);
    chk("count", count, q.size());
    chk("full", full, (q.size() == DEPTH) ? 1 : 0);
    chk("empty", empty, (q.size() == 0) ? 1 : 0);
    @(negedge clk);
  endtask

  task automatic idle();
    alloc_num = 2'd0; stop = 1'b0;
    res1_valid = 1'b0; res2_valid = 1'b0;
  endtask

  task automatic set_res1(input int tag, input logic we, input int rd, input logic [DATA_W-1:0] d);
    res1_valid = 1'b1; res1_tag = TAG_W'(tag); res1_we = we; res1_rd = REG_W'(rd); res1_data = d;
  endtask

  task automatic set_res2(input int tag, input logic we, input int rd, input logic [DATA_W-1:0] d);
    res2_valid = 1'b1; res2_tag = TAG_W'(tag); res2_we = we; res2_rd = REG_W'(rd); res2_data = d;
  endtask

  task automatic drain();
    int n;
    for (int it = 0; it < 40 && q.size() > 0; it++) begin
      idle();
      n = 0;
      for (int k = 0; k < q.size() && n < 2; k++) begin
        if (!q[k].done) begin
          if (n == 0) set_res1((m_head + k) % DEPTH, 1'b1, $urandom_range(0, 31), $urandom);
          else        set_res2((m_head + k) % DEPTH, 1'b1, $urandom_range(0, 31), $urandom);
          n++;
        end
      end
      tick();
    end
    idle();
    chk("drain_count", count, 0);
  endtask

  initial begin
    int t0, t1, busy[$];
    checks = 0; errors = 0;
    m_head = 0;
    e1_we = 0; e2_we = 0; e1_addr = '0; e2_addr = '0; e1_data = '0; e2_data = '0;
    rst = 1'b1; stop = 1'b0; alloc_num = 2'd0;
    res1_valid = 0; res1_tag = '0; res1_we = 0; res1_rd = '0; res1_data = '0;
    res2_valid = 0; res2_tag = '0; res2_we = 0; res2_rd = '0; res2_data = '0;
    @(negedge clk);
    tick();
    tick();
    rst = 1'b0;
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_wb1_we", wb1_we, 0);
    chk("rst_wb2_data", wb2_data, 0);

    // Out-of-order return of a pair, committed together.
    alloc_num = 2'd2;
    #1 chk("pair_ok", alloc_ok, 1);
    chk("pair_tag0", alloc_tag0, 0);
    chk("pair_tag1", alloc_tag1, 1);
    tick();
    idle(); set_res1(1, 1'b1, 5, 32'h11); tick();
    idle(); set_res1(0, 1'b1, 6, 32'h22); tick();
    chk("pair_nocommit_yet", wb1_we, 0);
    idle(); tick();
    chk("pair_wb1_we", wb1_we, 1);
    chk("pair_wb1_addr", wb1_addr, 6);
    chk("pair_wb1_data", wb1_data, 32'h22);
    chk("pair_wb2_we", wb2_we, 1);
    chk("pair_wb2_addr", wb2_addr, 5);
    chk("pair_wb2_data", wb2_data, 32'h11);
    chk("pair_count", count, 0);

    // Fill, reject when full, then reopen after a single commit.
    for (int i = 0; i < 8; i++) begin alloc_num = 2'd1; tick(); end
    idle();
    chk("fill_full", full, 1);
    alloc_num = 2'd1;
    #1 chk("full_reject", alloc_ok, 0);
    set_res1(m_head, 1'b1, 7, 32'h33); tick();
    idle(); tick();
    chk("full_commit_count", count, 7);
    alloc_num = 2'd1;
    #1 chk("full_reopen", alloc_ok, 1);
    tick();
    drain();

    // Same destination in one commit pair, then an rd=0 result.
    alloc_num = 2'd2; t0 = m_tail(); t1 = (t0 + 1) % DEPTH; tick();
    idle(); set_res1(t0, 1'b1, 3, 32'hA); set_res2(t1, 1'b1, 3, 32'hB); tick();
    idle(); tick();
    chk("samerd_wb1_we", wb1_we, 0);
    chk("samerd_wb2_we", wb2_we, 1);
    chk("samerd_wb2_data", wb2_data, 32'hB);
    alloc_num = 2'd1; t0 = m_tail(); tick();
    idle(); set_res1(t0, 1'b1, 0, 32'h55); tick();
    idle(); tick();
    chk("rd0_wb1_we", wb1_we, 0);

    // Hold with stop while results land, then drain two per cycle.
    alloc_num = 2'd2; t0 = m_tail(); tick();
    alloc_num = 2'd2; tick();
    idle(); stop = 1'b1;
    set_res1(t0, 1'b1, 9, 32'h90); set_res2((t0 + 1) % DEPTH, 1'b1, 10, 32'h91); tick();
    idle(); stop = 1'b1;
    set_res1((t0 + 3) % DEPTH, 1'b1, 12, 32'h93); set_res2((t0 + 2) % DEPTH, 1'b1, 11, 32'h92); tick();
    idle(); stop = 1'b1; tick();
    chk("stop_count", count, 4);
    chk("stop_wb2_we", wb2_we, 0);
    idle(); tick();
    chk("unstop_count1", count, 2);
    chk("unstop_wb1_addr", wb1_addr, 9);
    tick();
    chk("unstop_count0", count, 0);
    chk("unstop_wb2_data", wb2_data, 32'h93);

    // Walk the head to 7 and commit a pair across the wrap.
    for (int it = 0; it < 16 && m_head != 7; it++) begin
      alloc_num = 2'd1; t0 = m_tail(); tick();
      idle(); set_res1(t0, 1'b1, 1, $urandom); tick();
      idle(); tick();
    end
    alloc_num = 2'd2;
    #1 chk("wrap_tag0", alloc_tag0, 7);
    chk("wrap_tag1", alloc_tag1, 0);
    tick();
    idle(); set_res1(0, 1'b1, 20, 32'hC0); tick();
    idle(); set_res1(7, 1'b1, 21, 32'hC7); tick();
    idle(); tick();
    chk("wrap_wb1_addr", wb1_addr, 21);
    chk("wrap_wb2_addr", wb2_addr, 20);
    chk("wrap_count", count, 0);

    // Reset mid-stream; a stale result afterwards must be dropped.
    alloc_num = 2'd2; t0 = m_tail(); tick();
    idle(); set_res1(t0, 1'b1, 4, 32'h44); tick();
    idle(); rst = 1'b1; tick();
    rst = 1'b0;
    chk("midrst_count", count, 0);
    chk("midrst_wb1_we", wb1_we, 0);
    chk("midrst_wb1_addr", wb1_addr, 0);
    set_res1(1, 1'b1, 8, 32'h88); tick();
    idle(); tick();
    chk("stale_count", count, 0);
    chk("stale_wb1_we", wb1_we, 0);

    // Random traffic.
    for (int cyc = 0; cyc < 400; cyc++) begin
      idle();
      alloc_num = 2'($urandom_range(0, 2));
      stop = ($urandom_range(0, 9) == 0);
      busy.delete();
      for (int k = 0; k < q.size(); k++) if (!q[k].done) busy.push_back((m_head + k) % DEPTH);
      if ($urandom_range(0, 9) < 7) begin
        t0 = (busy.size() > 0 && $urandom_range(0, 3) != 0) ?
             busy[$urandom_range(0, busy.size() - 1)] : $urandom_range(0, DEPTH - 1);
        set_res1(t0, 1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom);
      end
      if ($urandom_range(0, 9) < 6) begin
        t1 = (busy.size() > 0 && $urandom_range(0, 3) != 0) ?
             busy[$urandom_range(0, busy.size() - 1)] : $urandom_range(0, DEPTH - 1);
        if (!(res1_valid && TAG_W'(t1) == res1_tag))
          set_res2(t1, 1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom);
      end
      tick();
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
